// File: rtl/board_ctrl_if.sv
// board_ctrl_if
// Groups the render-port, ship-ROM and fire-result signals of the board
// controller.
//   render_en / render_addr / render_state : renderer read port
//   ship_addr / ship_present               : ship-placement ROM lookup
//   busy                                   : clear sweep or fire in progress
//   result_valid / result_hit / result_dup : end-of-fire pulse + qualifiers
// The slave modport is the controller side; master is the game/renderer side.
interface board_ctrl_if;
  logic       render_en;
  logic [6:0] render_addr;
  logic [1:0] render_state;
  logic [6:0] ship_addr;
  logic       ship_present;
  logic       busy;
  logic       result_valid;
  logic       result_hit;
  logic       result_dup;

  modport slave (
    input  render_en, render_addr, ship_present,
    output render_state, ship_addr, busy, result_valid, result_hit, result_dup
  );

  modport master (
    output render_en, render_addr, ship_present,
    input  render_state, ship_addr, busy, result_valid, result_hit, result_dup
  );
endinterface

// File: rtl/board_ctrl.sv
// board_ctrl
// Battleship board controller: debounces the five buttons, owns the cursor,
// the 100x2-bit shot-state memory (single port, synchronous read) and the
// hit/shot counters.
//   clk, reset             : system clock, asynchronous active-high reset
//   i_btn_l/r/u/d/c        : raw buttons (c = fire)
//   bus (board_ctrl_if)    : render port, ship ROM port, busy and fire result
//   o_cursor_col/row       : cursor cell coordinates
//   o_score, o_shots       : hits so far, accepted shots
//   o_game_over            : sticky once score reaches SHIP_CELLS
module board_ctrl #(
  parameter int GRID_SIZE       = 10,
  parameter int DEBOUNCE_CYCLES = 2_500_000,
  parameter int SHIP_CELLS      = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_btn_l,
  input  logic              i_btn_r,
  input  logic              i_btn_u,
  input  logic              i_btn_d,
  input  logic              i_btn_c,
  board_ctrl_if.slave       bus,
  output logic [3:0]        o_cursor_col,
  output logic [3:0]        o_cursor_row,
  output logic [15:0]       o_score,
  output logic [7:0]        o_shots,
  output logic              o_game_over
);

  localparam int NCELLS = GRID_SIZE * GRID_SIZE;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [6:0]    GRID7   = 7'(GRID_SIZE);
  localparam logic [3:0]    MAXPOS  = 4'(GRID_SIZE - 1);
  localparam logic [6:0]    LASTC   = 7'(NCELLS - 1);
  localparam logic [15:0]   SHIP16  = 16'(SHIP_CELLS);
  localparam logic [CW-1:0] CNTLAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CLEAR, ST_IDLE, ST_RD, ST_CHK, ST_WR, ST_DONE
  } state_t;

  // ---------------- button conditioning ----------------
  logic [4:0]    w_btn_raw;
  logic [4:0]    r_sync1, r_sync2, r_deb, r_deb_d, r_press;
  logic [CW-1:0] r_cnt [5];

  assign w_btn_raw = {i_btn_c, i_btn_d, i_btn_u, i_btn_r, i_btn_l};

  // The debounced level follows the synchronised input only after it has
  // differed for DEBOUNCE_CYCLES consecutive samples; the press pulse is a
  // registered rising-edge detect of that level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNTLAST) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- cursor ----------------
  logic [3:0] r_col, r_row;
  logic [6:0] w_cursor_addr;

  // L has priority over R and U over D when both pulse in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (r_press[0]) begin
        if (r_col != 4'd0) r_col <= r_col - 4'd1;
      end else if (r_press[1]) begin
        if (r_col != MAXPOS) r_col <= r_col + 4'd1;
      end
      if (r_press[2]) begin
        if (r_row != 4'd0) r_row <= r_row - 4'd1;
      end else if (r_press[3]) begin
        if (r_row != MAXPOS) r_row <= r_row + 4'd1;
      end
    end
  end

  assign w_cursor_addr = ({3'b000, r_row} * GRID7) + {3'b000, r_col};
  assign o_cursor_col  = r_col;
  assign o_cursor_row  = r_row;

  // ---------------- shot-state memory port ----------------
  state_t     r_state;
  logic [6:0] r_clr_idx, r_addr, r_ship_addr;
  logic       r_hit, r_dup, r_result_valid, r_game_over;
  logic [1:0] r_cell, r_render_state;
  logic [15:0] r_score;
  logic [7:0]  r_shots;
  logic [1:0] r_mem [NCELLS];
  logic       w_mem_we;
  logic [6:0] w_mem_addr;
  logic [1:0] w_mem_wdata, w_mem_rdata;
  logic [15:0] w_score_inc;

  // One access per cycle: the clear sweep owns the port, then the renderer,
  // and the fire sequencer only gets it when render_en is low.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr;
    w_mem_wdata = 2'd0;
    if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_idx;
    end else if (bus.render_en) begin
      w_mem_addr = bus.render_addr;
    end else if (r_state == ST_WR) begin
      w_mem_we    = 1'b1;
      w_mem_wdata = r_hit ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign w_mem_rdata = r_mem[w_mem_addr];
  assign w_score_inc = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;

  // ---------------- fire sequencer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_CLEAR;
      r_clr_idx      <= '0;
      r_addr         <= '0;
      r_ship_addr    <= '0;
      r_cell         <= '0;
      r_hit          <= 1'b0;
      r_dup          <= 1'b0;
      r_result_valid <= 1'b0;
      r_render_state <= '0;
      r_score        <= '0;
      r_shots        <= '0;
      r_game_over    <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (r_state == ST_CLEAR) r_render_state <= 2'd0;
      else if (bus.render_en)  r_render_state <= w_mem_rdata;

      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == LASTC) r_state <= ST_IDLE;
          else                    r_clr_idx <= r_clr_idx + 7'd1;
        end
        ST_IDLE: begin
          if (r_press[4] && !r_game_over) begin
            r_addr      <= w_cursor_addr;
            r_ship_addr <= w_cursor_addr;
            r_state     <= ST_RD;
          end
        end
        ST_RD: begin
          if (!bus.render_en) begin
            r_cell  <= w_mem_rdata;
            r_state <= ST_CHK;
          end
        end
        ST_CHK: begin
          // ship_present has had a full cycle to settle on r_ship_addr.
          if (r_cell != 2'd0) begin
            r_dup          <= 1'b1;
            r_hit          <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= ST_DONE;
          end else begin
            r_dup   <= 1'b0;
            r_hit   <= bus.ship_present;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (!bus.render_en) begin
            r_shots <= r_shots + 8'd1;
            if (r_hit) begin
              r_score <= w_score_inc;
              if (w_score_inc >= SHIP16) r_game_over <= 1'b1;
            end
            r_result_valid <= 1'b1;
            r_state        <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.render_state = r_render_state;
  assign bus.ship_addr    = r_ship_addr;
  assign bus.result_valid = r_result_valid;
  assign bus.result_hit   = r_hit;
  assign bus.result_dup   = r_dup;
  assign o_score          = r_score;
  assign o_shots          = r_shots;
  assign o_game_over      = r_game_over;

endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl
// Self-checking bench for board_ctrl with short debounce and a two-hit game.
module tb_board_ctrl;
  localparam int DEB   = 4;
  localparam int SHIPS = 2;
  localparam int GRID  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnC = 1'b0;
  logic [3:0]  cursorCol, cursorRow;
  logic [15:0] score;
  logic [7:0]  shots;
  logic        gameOver;

  board_ctrl_if bus();

  int total = 0;
  int bad   = 0;
  bit shipMap [128];

  // reference model state
  int mCol, mRow, mScore, mShots;
  bit mOver;
  int mCells [100];

  typedef struct {
    logic [4:0] mask;
    int         expCol;
    int         expRow;
  } moveVec_t;

  board_ctrl #(.GRID_SIZE(GRID), .DEBOUNCE_CYCLES(DEB), .SHIP_CELLS(SHIPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_btn_l      (btnL),
    .i_btn_r      (btnR),
    .i_btn_u      (btnU),
    .i_btn_d      (btnD),
    .i_btn_c      (btnC),
    .bus          (bus),
    .o_cursor_col (cursorCol),
    .o_cursor_row (cursorRow),
    .o_score      (score),
    .o_shots      (shots),
    .o_game_over  (gameOver)
  );

  always #5 clk = ~clk;

  // ship-placement ROM: data valid one cycle after the address
  always @(posedge clk) bus.ship_present <= shipMap[bus.ship_addr];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    mCol = 0; mRow = 0; mScore = 0; mShots = 0; mOver = 0;
    for (int i = 0; i < 100; i++) mCells[i] = 0;
  endtask

  task automatic doReset(input bit checkVals);
    int busyCycles;
    int strayRender;
    @(negedge clk);
    reset = 1'b1;
    {btnC, btnD, btnU, btnR, btnL} = 5'b0;
    bus.render_en = 1'b0;
    #1;
    if (checkVals) begin
      checkOutput("rst_col",      32'(cursorCol), 0);
      checkOutput("rst_row",      32'(cursorRow), 0);
      checkOutput("rst_score",    32'(score), 0);
      checkOutput("rst_shots",    32'(shots), 0);
      checkOutput("rst_gameover", 32'(gameOver), 0);
      checkOutput("rst_valid",    32'(bus.result_valid), 0);
      checkOutput("rst_hit",      32'(bus.result_hit), 0);
      checkOutput("rst_dup",      32'(bus.result_dup), 0);
      checkOutput("rst_shipaddr", 32'(bus.ship_addr), 0);
      checkOutput("rst_render",   32'(bus.render_state), 0);
      checkOutput("rst_busy",     32'(bus.busy), 1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busyCycles  = -1;
    strayRender = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.busy == 1'b0) begin
        busyCycles = i;
        break;
      end
      if (bus.render_state !== 2'd0) strayRender++;
      bus.render_en   = (i % 3 == 0);
      bus.render_addr = 7'(i % 100);
    end
    bus.render_en = 1'b0;
    checkOutput("clear_busy_cycles", busyCycles, 100);
    checkOutput("clear_render_forced0", strayRender, 0);
    resetModel();
  endtask

  task automatic readCell(input int a, output logic [1:0] st);
    bus.render_en   = 1'b1;
    bus.render_addr = 7'(a);
    @(negedge clk);
    st = bus.render_state;
    bus.render_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] mask);
    @(negedge clk);
    {btnC, btnD, btnU, btnR, btnL} = mask;
    repeat (12) @(negedge clk);
    {btnC, btnD, btnU, btnR, btnL} = 5'b0;
    repeat (12) @(negedge clk);
  endtask

  // Presses fire at cycle 0; render_en is held high for stallLen cycles
  // starting at cycle 8, when the sequencer is waiting to read.
  task automatic fireShot(input int stallLen, output int pulses, output int lat,
                          output logic hit, output logic dup, output int sc,
                          output int sh, output logic go, output int sa);
    pulses = 0; lat = -1; hit = 0; dup = 0; sc = 0; sh = 0; go = 0; sa = 0;
    @(negedge clk);
    btnC = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = i; hit = bus.result_hit; dup = bus.result_dup;
          sc = 32'(score); sh = 32'(shots); go = gameOver; sa = 32'(bus.ship_addr);
        end
      end
      if (i == 10) btnC = 1'b0;
      bus.render_en   = (i >= 8 && i < 8 + stallLen);
      bus.render_addr = 7'($urandom_range(0, 99));
    end
    bus.render_en = 1'b0;
  endtask

  task automatic checkFire(input int stall, input bit expResult, input int expLat,
                           input logic expHit, input logic expDup, input int expScore,
                           input int expShots, input logic expGo, input int expAddr);
    int pulses, lat, sc, sh, sa;
    logic hit, dup, go;
    fireShot(stall, pulses, lat, hit, dup, sc, sh, go, sa);
    checkOutput("fire_pulses", pulses, expResult ? 1 : 0);
    if (expResult) begin
      checkOutput("fire_latency",  lat, expLat);
      checkOutput("fire_hit",      32'(hit), 32'(expHit));
      checkOutput("fire_dup",      32'(dup), 32'(expDup));
      checkOutput("fire_score",    sc, expScore);
      checkOutput("fire_shots",    sh, expShots);
      checkOutput("fire_gameover", 32'(go), 32'(expGo));
      checkOutput("fire_shipaddr", sa, expAddr);
    end else begin
      checkOutput("drop_latency", lat, -1);
      checkOutput("drop_score",   32'(score), expScore);
      checkOutput("drop_shots",   32'(shots), expShots);
    end
  endtask

  // Reference model of a fire press at the current cursor.
  task automatic modelFire(input int stall);
    int a;
    bit h;
    a = mRow * GRID + mCol;
    if (mOver) begin
      checkFire(stall, 0, 0, 0, 0, mScore, mShots, 1, 0);
    end else if (mCells[a] != 0) begin
      checkFire(stall, 1, 10 + stall, 0, 1, mScore, mShots, mOver, a);
    end else begin
      h = shipMap[a];
      mCells[a] = h ? 2 : 1;
      mShots++;
      if (h) mScore++;
      if (mScore >= SHIPS) mOver = 1;
      checkFire(stall, 1, 11 + stall, h, 0, mScore, mShots, mOver, a);
    end
  endtask

  task automatic modelMove(input logic [4:0] mask);
    if (mask[0])      mCol = (mCol > 0) ? mCol - 1 : 0;
    else if (mask[1]) mCol = (mCol < GRID - 1) ? mCol + 1 : GRID - 1;
    if (mask[2])      mRow = (mRow > 0) ? mRow - 1 : 0;
    else if (mask[3]) mRow = (mRow < GRID - 1) ? mRow + 1 : GRID - 1;
  endtask

  initial begin
    moveVec_t moveTab [13];
    logic [1:0] st;
    int nz;
    logic [4:0] mask;
    int act;

    moveTab[0]  = '{5'b00100, 1, 0};
    moveTab[1]  = '{5'b00100, 1, 0};
    moveTab[2]  = '{5'b00100, 1, 0};
    moveTab[3]  = '{5'b00100, 1, 0};
    moveTab[4]  = '{5'b00011, 0, 0};
    moveTab[5]  = '{5'b00001, 0, 0};
    moveTab[6]  = '{5'b00010, 1, 0};
    moveTab[7]  = '{5'b00010, 2, 0};
    moveTab[8]  = '{5'b00010, 3, 0};
    moveTab[9]  = '{5'b01000, 3, 1};
    moveTab[10] = '{5'b01000, 3, 2};
    moveTab[11] = '{5'b01100, 3, 1};
    moveTab[12] = '{5'b01000, 3, 2};

    for (int i = 0; i < 128; i++) shipMap[i] = 0;
    shipMap[23] = 1;
    shipMap[25] = 1;
    bus.render_en   = 1'b0;
    bus.render_addr = '0;

    $display("[TB] reset and clear sweep");
    doReset(1);
    nz = 0;
    for (int a = 0; a < 100; a++) begin
      readCell(a, st);
      if (st !== 2'd0) nz++;
    end
    checkOutput("clear_cells_nonzero", nz, 0);

    $display("[TB] debounce");
    @(negedge clk);
    btnR = 1'b1;
    repeat (3) @(negedge clk);
    btnR = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("glitch_col", 32'(cursorCol), 0);

    btnR = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("press_col_before", 32'(cursorCol), 0);
    @(negedge clk);
    checkOutput("press_col_after", 32'(cursorCol), 1);
    repeat (4) @(negedge clk);
    btnR = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] cursor table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(moveTab[i].mask);
      checkOutput($sformatf("tab%0d_col", i), 32'(cursorCol), moveTab[i].expCol);
      checkOutput($sformatf("tab%0d_row", i), 32'(cursorRow), moveTab[i].expRow);
    end

    $display("[TB] fire sequences");
    checkFire(0, 1, 11, 1, 0, 1, 1, 0, 23);
    readCell(23, st);
    checkOutput("cell23", 32'(st), 2);
    checkFire(0, 1, 10, 0, 1, 1, 1, 0, 23);

    applyStimulus(5'b00010);
    checkFire(50, 1, 61, 0, 0, 1, 2, 0, 24);
    readCell(24, st);
    checkOutput("cell24", 32'(st), 1);

    applyStimulus(5'b00010);
    checkFire(0, 1, 11, 1, 0, 2, 3, 1, 25);
    applyStimulus(5'b00010);
    checkFire(0, 0, 0, 0, 0, 2, 3, 1, 0);
    checkOutput("gameover_sticky", 32'(gameOver), 1);
    doReset(0);
    checkOutput("gameover_cleared", 32'(gameOver), 0);
    checkOutput("shots_cleared", 32'(shots), 0);

    for (int i = 0; i < 11; i++) applyStimulus(5'b00010);
    checkOutput("sat_col_max", 32'(cursorCol), GRID - 1);
    for (int i = 0; i < 11; i++) applyStimulus(5'b01000);
    checkOutput("sat_row_max", 32'(cursorRow), GRID - 1);

    $display("[TB] randomized run");
    for (int i = 0; i < 100; i++) shipMap[i] = ($urandom_range(0, 99) < 15);
    doReset(0);
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        mask = 5'($urandom_range(1, 15));
        applyStimulus(mask);
        modelMove(mask);
        checkOutput("rnd_col", 32'(cursorCol), mCol);
        checkOutput("rnd_row", 32'(cursorRow), mRow);
      end else if (act <= 8) begin
        modelFire($urandom_range(0, 4));
      end else begin
        nz = $urandom_range(0, 99);
        readCell(nz, st);
        checkOutput("rnd_cell", 32'(st), mCells[nz]);
      end
      if (mOver && $urandom_range(0, 2) == 0) doReset(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_ctrl.md
# board_ctrl

Game-side controller for the battleship grid display. It debounces the five board buttons and owns the cursor cell position, which the renderer uses to place the cursor sprite. It also holds the 100-cell shot-state memory and arbitrates that single-port memory between the VGA renderer (read) and the fire sequencer (read-modify-write). It keeps the hit and shot counters and sits between the raw button pins and the pixel mux / score display.

## Interface
- GRID_SIZE, 10: cells per row and per column.
- DEBOUNCE_CYCLES, 2_500_000: stable cycles required before a button level is accepted (25 ms at 100 MHz).
- SHIP_CELLS, 17: hit count that ends the game.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_l, btn_r, btn_u, btn_d, btn_c  in  1 each  raw, unsynchronised buttons; btn_c is fire.
- render_en  in  1  renderer is reading this cycle (bright and inside grid).
- render_addr  in  7  cell index = row*GRID_SIZE+col requested by the renderer.
- render_state  out  2  cell state for render_addr: 0 unknown, 1 miss, 2 hit.
- ship_addr  out  7  cell index presented to the ship-placement ROM.
- ship_present  in  1  ROM data, valid 1 cycle after ship_addr changes.
- cursor_col, cursor_row  out  4 each  cursor cell coordinates.
- busy  out  1  clear sweep or fire sequence in progress.
- result_valid  out  1  one-cycle pulse at the end of each fire.
- result_hit, result_dup  out  1 each  qualifiers for result_valid.
- score  out  16  hits so far.
- shots  out  8  accepted (non-duplicate) shots.
- game_over  out  1  score reached SHIP_CELLS; sticky until reset.

## Operation
- **Button conditioning.** Each button goes through a 2-flop synchroniser, then a counter. The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. A rising edge of the debounced level produces a one-cycle press pulse. There is no auto-repeat.
- **Cursor movement.**
  - One press moves one cell; position saturates at 0 and GRID_SIZE-1.
  - Horizontal and vertical moves are independent.
  - L beats R and U beats D when pressed in the same cycle.
  - The cursor moves freely while busy.
- **Memory.** The shot-state memory is 100×2 bits, single port, with synchronous read.
  - Priority: clear sweep > renderer > fire sequencer.
  - When render_en=1, the port reads render_addr and render_state updates on the next cycle.
  - Otherwise render_state holds its last value.
- **FSM states: CLEAR, IDLE, RD, CHK, WR, DONE.**
  - CLEAR: entered on reset. Writes 0 to cells 0..99, one per cycle, ignoring render_en. render_state is forced to 0. Goes to IDLE after cell 99.
  - IDLE: on a fire press with !game_over, latch addr = cursor_row*GRID_SIZE+cursor_col, drive ship_addr=addr, go to RD. Fire presses in any other state, or when game_over=1, are dropped.
  - RD: wait while render_en=1. Otherwise read addr and go to CHK.
  - CHK: if state≠0, set dup and go to DONE. Otherwise capture ship_present and go to WR.
  - WR: wait while render_en=1. Otherwise:
    - write 2 if hit, else 1;
    - increment shots;
    - increment score on a hit (16-bit, saturating at FFFF);
    - go to DONE.
  - DONE: pulse result_valid with result_hit/result_dup, then go to IDLE. game_over sets the cycle score becomes SHIP_CELLS.
- busy=1 in every state except IDLE.

## Timing
- **Reset values.**
  - cursor_col=0, cursor_row=0, render_state=0, ship_addr=0.
  - result_valid=0, result_hit=0, result_dup=0.
  - score=0, shots=0, game_over=0.
  - busy=1 (CLEAR); busy=0 from reset release + 100 cycles.
- **Press latency.** A clean button level change produces its press pulse DEBOUNCE_CYCLES+3 cycles after the input change. The cursor updates on the cycle after the pulse.
- **Fire latency with render_en low.**
  - Press pulse at cycle N; FSM is in RD at N+1, CHK at N+2, WR at N+3, DONE at N+4.
  - result_valid is high during N+4; score and shots are visible at N+4.
  - Each cycle of render_en=1 in RD or WR adds exactly one cycle.
- **Duplicate shot.** result_valid is high at N+3; there is no write and no counter change.
- **Reset mid-sequence.** Asynchronously aborts and restarts CLEAR. No partial write is permitted after reset assertion.

## Test plan
1. Reset, render_en=0 → busy=1 for 100 cycles, then 0; all 100 cells read back 0 via the render port.
2. DEBOUNCE_CYCLES=4; 3-cycle glitch on btn_r → no move; clean 10-cycle press → cursor_col 0→1. Four U presses at row 0 → cursor_row stays 0. L and R in the same cycle at col 1 → col 0.
3. Cursor (3,2), ship_present=1 for addr 23, fire with render_en=0 → result_valid at N+4 with hit=1; score=1, shots=1; render read of 23 returns 2.
4. Fire again at (3,2) → result_valid at N+3 with dup=1; score and shots unchanged.
5. Fire at a miss cell with render_en held high 50 cycles after the press → result_valid at N+54 with hit=0; cell reads 1.
6. SHIP_CELLS=2, two distinct hits → game_over=1 in the DONE cycle of the second hit. A further fire press produces no result_valid. Reset clears game_over.
